spm_port_arbiter: RTL
=====================

// Module: spm_port_arbiter
// PURPOSE
//  Shares the single-port scratchpad (spm) between three requesters: instruction fetch (if_stage),
//  load/store (mem stage) and a boot/debug loader. Grants one access per cycle and returns read data
//  one cycle later, tagged to the owning requester. Issues per-requester ready flags so the pipeline stalls.
//  Sits between if_stage/mem stage and spm; spm sees only the arbiter's single port.
// PARAMETERS
//  ADDR_W      30  word-address width (matches `WORD_ADDR_BUS)
//  DATA_W      32  data width (matches `DATA_WIDTH_INSN)
//  STARVE_MAX  4   consecutive denied fetch cycles before fetch is promoted above mem
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-high
//  if_as_       in   1       fetch request strobe, active-low, read only
//  if_addr      in   ADDR_W  fetch word address
//  if_rdy       out  1       fetch granted this cycle
//  if_rd_valid  out  1       if_rd_data valid (cycle after grant)
//  if_rd_data   out  DATA_W  fetched instruction
//  mem_as_      in   1       load/store strobe, active-low
//  mem_rw       in   1       `READ / `WRITE
//  mem_addr     in   ADDR_W  load/store word address
//  mem_wr_data  in   DATA_W  store data
//  mem_rdy      out  1       load/store granted this cycle
//  mem_rd_valid out  1       mem_rd_data valid (cycle after granted read)
//  mem_rd_data  out  DATA_W  load data
//  ldr_as_      in   1       loader write strobe, active-low, write only
//  ldr_addr     in   ADDR_W  loader word address
//  ldr_wr_data  in   DATA_W  loader data
//  ldr_rdy      out  1       loader granted this cycle
//  spm_as_      out  1       to spm, active-low
//  spm_rw       out  1       to spm
//  spm_addr     out  ADDR_W  to spm
//  spm_wr_data  out  DATA_W  to spm
//  spm_rd_data  in   DATA_W  from spm, valid one cycle after read access
// BEHAVIOUR
//  - Grant is combinational from current strobes + registered state; at most one of *_rdy high per cycle.
//  - Priority: ldr > mem > if, except when starve_cnt == STARVE_MAX: ldr > if > mem.
//  - Granted requester's addr/rw/data muxed onto spm_*; no grant -> spm_as_=1, spm_rw=`READ, addr/data 0.
//  - Requester not granted must hold its request; arbiter keeps no queue.
//  - owner_q (NONE/IF/MEM) registers the owner of a granted read; spm_rd_data routed next cycle to that
//    requester with its *_rd_valid=1. Writes set owner_q=NONE. Back-to-back reads: owner_q updates each cycle.
//  - *_rd_data driven from spm_rd_data unconditionally; valid flags qualify them.
//  - starve_cnt (width clog2(STARVE_MAX+1)): +1 when if_as_=0 and !if_rdy, saturates at STARVE_MAX;
//    cleared on if_rdy or if_as_=1.
//  - Loader traffic never promoted or demoted; fetch promotion never overrides loader.
//  - Reset (async): owner_q=NONE, starve_cnt=0; all *_rd_valid=0, spm_as_=1. Read in flight at reset is
//    discarded (no valid after deassertion). *_rdy derived combinationally but forced 0 while reset=1.
//  - Read-after-write same address, consecutive cycles: spm ordering; arbiter adds no forwarding.
// STRUCTURE
//  - Owner encodings OWN_NONE/OWN_IF/OWN_MEM and STARVE_MAX default go in define.v beside `READ/`WRITE.
//  - Single module; no sub-module (grant logic + two registers).
// TESTING
//  1 reset=1 with all strobes low -> every *_rdy=0, spm_as_=1; release -> owner_q NONE, no rd_valid.
//  2 ldr writes 0xF0168093 @0, 0x00F6A093 @1; then if reads @0,@1 -> if_rd_valid next cycles, data match.
//  3 if and mem read together, STARVE_MAX=4, mem held 6 cycles -> mem wins 4, if granted cycle 5, mem 6.
//  4 ldr, mem, if all request -> ldr_rdy only; spm_rw=`WRITE; no rd_valid next cycle.
//  5 mem write 0xDEADBEEF @8 then mem read @8 -> mem_rd_valid=1, mem_rd_data=0xDEADBEEF, if_rd_valid=0.
//  6 reset asserted the cycle after a granted if read -> if_rd_valid stays 0 through and after reset.

Source files
------------

// File: rtl/spm_port_arbiter_pkg.sv
// Shared encodings for the scratchpad port arbiter: bus direction, read-owner tags
// and the default fetch starvation limit.
package spm_port_arbiter_pkg;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

endpackage

// File: rtl/spm_port_arbiter.sv
// Single-port scratchpad arbiter for fetch, load/store and boot loader.
// Handshake: a requester holds its active-low strobe and its fields until its *_rdy is high in that cycle.
module spm_port_arbiter
    import spm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_as_,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rdy,
    output logic              if_rd_valid,
    output logic [DATA_W-1:0] if_rd_data,
    input  logic              mem_as_,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rdy,
    output logic              mem_rd_valid,
    output logic [DATA_W-1:0] mem_rd_data,
    input  logic              ldr_as_,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wr_data,
    output logic              ldr_rdy,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [ADDR_W-1:0] spm_addr,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              promote;

    always_comb begin
        if_rdy       = 1'b0;
        mem_rdy      = 1'b0;
        ldr_rdy      = 1'b0;
        spm_as_      = 1'b1;
        spm_rw       = READ;
        spm_addr     = '0;
        spm_wr_data  = '0;
        owner_d      = OWN_NONE;
        starve_cnt_d = '0;
        promote      = (starve_cnt_q == CNT_MAX);

        // Starved fetch only jumps over mem; the loader always wins.
        if (!reset) begin
            if (!ldr_as_)                  ldr_rdy = 1'b1;
            else if (promote && !if_as_)   if_rdy  = 1'b1;
            else if (!mem_as_)             mem_rdy = 1'b1;
            else if (!if_as_)              if_rdy  = 1'b1;
        end

        if (ldr_rdy) begin
            spm_as_     = 1'b0;
            spm_rw      = WRITE;
            spm_addr    = ldr_addr;
            spm_wr_data = ldr_wr_data;
        end else if (mem_rdy) begin
            spm_as_     = 1'b0;
            spm_rw      = mem_rw;
            spm_addr    = mem_addr;
            spm_wr_data = mem_wr_data;
            if (mem_rw == READ) owner_d = OWN_MEM;
        end else if (if_rdy) begin
            spm_as_     = 1'b0;
            spm_rw      = READ;
            spm_addr    = if_addr;
            owner_d     = OWN_IF;
        end

        if (!if_as_ && !if_rdy)
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign if_rd_valid  = (owner_q == OWN_IF)  && !reset;
    assign mem_rd_valid = (owner_q == OWN_MEM) && !reset;
    assign if_rd_data   = spm_rd_data;
    assign mem_rd_data  = spm_rd_data;

endmodule
